// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU: operand capture with forwarding,
// load-use interlock and valid/ready handshakes. Define ID_EX_FWD_EN to enable forwarding.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 6,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic              in_use_pc,
  input  logic [CTRL_W-1:0] in_alu_ctrl,
  input  logic              in_reg_we,
  input  logic              exm_valid,
  input  logic              exm_we,
  input  logic              exm_is_load,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   srca,
  output logic [XLEN-1:0]   srcb,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs2,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_reg_we
);

  localparam logic [RA_W-1:0] X0 = {RA_W{1'b0}};

  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic [XLEN-1:0]   r_imm;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic              r_use_imm;
  logic              r_use_pc;
  logic              r_reg_we;
  logic              r_valid;
  logic [CTRL_W-1:0] r_alu_ctrl;

  logic              w_exm_wr;
  logic              w_load_use;
  logic              w_interlock;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_hold;
  logic [XLEN-1:0]   w_cap_op1;
  logic [XLEN-1:0]   w_cap_op2;
  logic [XLEN-1:0]   w_ref_op1;
  logic [XLEN-1:0]   w_ref_op2;

  // x0 is hardwired, so it never matches a producer
  function automatic logic src_hit(input logic [RA_W-1:0] rs,
                                   input logic [RA_W-1:0] prd,
                                   input logic            pwe);
    return (rs != X0) && pwe && (rs == prd);
  endfunction

  assign w_exm_wr   = exm_valid & exm_we;
  assign w_load_use = in_valid & w_exm_wr & exm_is_load &
                      (src_hit(in_rs1, exm_rd, 1'b1) | src_hit(in_rs2, exm_rd, 1'b1));

`ifdef ID_EX_FWD_EN
  logic w_exm_fwd;

  function automatic logic [XLEN-1:0] fwd_pick(input logic            exm_h,
                                               input logic            wb_h,
                                               input logic [XLEN-1:0] exm_d,
                                               input logic [XLEN-1:0] wb_d,
                                               input logic [XLEN-1:0] dflt);
    logic [XLEN-1:0] v;
    if (exm_h) begin
      v = exm_d;
    end else if (wb_h) begin
      v = wb_d;
    end else begin
      v = dflt;
    end
    return v;
  endfunction

  // A load in EX/MEM has no data yet; it is covered by the interlock instead
  assign w_exm_fwd   = w_exm_wr & ~exm_is_load;
  assign w_interlock = w_load_use;

  assign w_cap_op1 = fwd_pick(src_hit(in_rs1, exm_rd, w_exm_fwd), src_hit(in_rs1, wb_rd, wb_we),
                              exm_data, wb_data, in_rs1_val);
  assign w_cap_op2 = fwd_pick(src_hit(in_rs2, exm_rd, w_exm_fwd), src_hit(in_rs2, wb_rd, wb_we),
                              exm_data, wb_data, in_rs2_val);
  assign w_ref_op1 = fwd_pick(src_hit(r_rs1, exm_rd, w_exm_fwd), src_hit(r_rs1, wb_rd, wb_we),
                              exm_data, wb_data, r_op1);
  assign w_ref_op2 = fwd_pick(src_hit(r_rs2, exm_rd, w_exm_fwd), src_hit(r_rs2, wb_rd, wb_we),
                              exm_data, wb_data, r_op2);
`else
  logic w_raw;
  logic w_unused;

  // Without forwarding, any in-flight write to a source must retire to the regfile first
  assign w_raw = src_hit(in_rs1, exm_rd, w_exm_wr) | src_hit(in_rs2, exm_rd, w_exm_wr) |
                 src_hit(in_rs1, wb_rd, wb_we)     | src_hit(in_rs2, wb_rd, wb_we);
  assign w_interlock = w_load_use | w_raw;

  assign w_cap_op1 = in_rs1_val;
  assign w_cap_op2 = in_rs2_val;
  assign w_ref_op1 = r_op1;
  assign w_ref_op2 = r_op2;
  assign w_unused  = ^{exm_data, wb_data, r_rs1, r_rs2};
`endif

  assign w_in_ready = (~r_valid | out_ready) & ~w_interlock & ~flush;
  assign w_accept   = in_valid & w_in_ready;
  assign w_hold     = r_valid & ~out_ready;

  // Entry register: capture on handshake, operand refresh while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= {XLEN{1'b0}};
      r_op1      <= {XLEN{1'b0}};
      r_op2      <= {XLEN{1'b0}};
      r_imm      <= {XLEN{1'b0}};
      r_rs1      <= {RA_W{1'b0}};
      r_rs2      <= {RA_W{1'b0}};
      r_rd       <= {RA_W{1'b0}};
      r_use_imm  <= 1'b0;
      r_use_pc   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_alu_ctrl <= {CTRL_W{1'b0}};
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      if (w_accept) begin
        r_pc       <= in_pc;
        r_op1      <= w_cap_op1;
        r_op2      <= w_cap_op2;
        r_imm      <= in_imm;
        r_rs1      <= in_rs1;
        r_rs2      <= in_rs2;
        r_rd       <= in_rd;
        r_use_imm  <= in_use_imm;
        r_use_pc   <= in_use_pc;
        r_reg_we   <= in_reg_we;
        r_alu_ctrl <= in_alu_ctrl;
      end else if (w_hold) begin
        r_op1 <= w_ref_op1;
        r_op2 <= w_ref_op2;
      end else begin
        r_op1 <= r_op1;
        r_op2 <= r_op2;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_valid;
  assign srca       = r_use_pc  ? r_pc  : r_op1;
  assign srcb       = r_use_imm ? r_imm : r_op2;
  assign alu_ctrl   = r_alu_ctrl;
  assign out_pc     = r_pc;
  assign out_rs2    = r_op2;
  assign out_rd     = r_rd;
  assign out_reg_we = r_reg_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage; a scoreboard queue holds the expected entry.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic        in_use_pc;
  logic [5:0]  in_alu_ctrl;
  logic        in_reg_we;
  logic        exm_valid;
  logic        exm_we;
  logic        exm_is_load;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [5:0]  alu_ctrl;
  logic [31:0] out_pc;
  logic [31:0] out_rs2;
  logic [4:0]  out_rd;
  logic        out_reg_we;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_imm;
    logic        use_pc;
    logic [5:0]  ctrl;
    logic        we;
  } ent_t;

  ent_t sb_q[$];
  logic m_valid;
  logic last_acc;
  int   checks;
  int   failures;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_alu_ctrl(in_alu_ctrl),
    .in_reg_we(in_reg_we), .exm_valid(exm_valid), .exm_we(exm_we),
    .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .srca(srca), .srcb(srcb),
    .alu_ctrl(alu_ctrl), .out_pc(out_pc), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_we(out_reg_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] dflt);
    if (rs != 5'd0 && exm_valid && exm_we && !exm_is_load && exm_rd == rs) return exm_data;
    else if (rs != 5'd0 && wb_we && wb_rd == rs) return wb_data;
    else return dflt;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_pc = 32'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_imm = 32'd0;
    in_use_imm = 1'b0; in_use_pc = 1'b0; in_alu_ctrl = 6'd0; in_reg_we = 1'b0;
    exm_valid = 1'b0; exm_we = 1'b0; exm_is_load = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic ui, input logic up,
                       input logic [5:0] ctrl, input logic we);
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_use_imm = ui; in_use_pc = up;
    in_alu_ctrl = ctrl; in_reg_we = we;
  endtask

  // One clock: predict ready/accept, update scoreboard at the edge, compare after it
  task automatic cycle();
    ent_t e;
    ent_t h;
    logic hz, raw, rdy, acc;
    #1;
    hz = in_valid && exm_valid && exm_we && exm_is_load && (exm_rd != 5'd0) &&
         (exm_rd == in_rs1 || exm_rd == in_rs2);
    raw = 1'b0;
    if (!FWD)
      raw = (in_rs1 != 5'd0 && ((exm_valid && exm_we && exm_rd == in_rs1) || (wb_we && wb_rd == in_rs1))) ||
            (in_rs2 != 5'd0 && ((exm_valid && exm_we && exm_rd == in_rs2) || (wb_we && wb_rd == in_rs2)));
    rdy = (!m_valid || out_ready) && !hz && !raw && !flush;
    if (in_valid) chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = in_valid && rdy;
    last_acc = acc;
    e.pc = in_pc; e.imm = in_imm; e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
    e.use_imm = in_use_imm; e.use_pc = in_use_pc; e.ctrl = in_alu_ctrl; e.we = in_reg_we;
    e.op1 = FWD ? model_fwd(in_rs1, in_rs1_val) : in_rs1_val;
    e.op2 = FWD ? model_fwd(in_rs2, in_rs2_val) : in_rs2_val;
    if (FWD && m_valid && !out_ready && sb_q.size() > 0) begin
      h = sb_q[0];
      h.op1 = model_fwd(h.rs1, h.op1);
      h.op2 = model_fwd(h.rs2, h.op2);
      sb_q[0] = h;
    end
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
      sb_q.delete();
    end else if (acc) begin
      sb_q.delete();
      sb_q.push_back(e);
      m_valid = 1'b1;
    end else if (out_ready) begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid && sb_q.size() > 0) begin
      h = sb_q[0];
      chk("srca", srca, h.use_pc ? h.pc : h.op1);
      chk("srcb", srcb, h.use_imm ? h.imm : h.op2);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(h.ctrl));
      chk("out_pc", out_pc, h.pc);
      chk("out_rs2", out_rs2, h.op2);
      chk("out_rd", 32'(out_rd), 32'(h.rd));
      chk("out_reg_we", 32'(out_reg_we), 32'(h.we));
    end
  endtask

  initial begin
    logic [31:0] exp_stall;
    checks = 0; failures = 0; m_valid = 1'b0; last_acc = 1'b0;
    rst_n = 1'b0; out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_reg_we", 32'(out_reg_we), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_srca", srca, 32'd0);
    chk("rst_srcb", srcb, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_rs2", out_rs2, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    rst_n = 1'b1;

    // basic add, then back-to-back immediate/PC select
    offer(32'h0, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1);
    cycle();
    chk("add_srca", srca, 32'd5);
    chk("add_srcb", srcb, 32'd7);
    chk("add_ctrl", 32'(alu_ctrl), 32'd0);
    offer(32'h100, 5'd1, 5'd2, 5'd6, 32'd5, 32'd7, 32'hFFFF_FFFC, 1'b1, 1'b1, 6'd3, 1'b1);
    cycle();
    chk("imm_srca", srca, 32'h100);
    chk("imm_srcb", srcb, 32'hFFFF_FFFC);

    // forwarding priority: EX/MEM beats WB
    offer(32'h104, 5'd3, 5'd0, 5'd7, 32'h33, 32'h0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1);
    exm_valid = 1'b1; exm_we = 1'b1; exm_rd = 5'd3; exm_data = 32'h11;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h22;
    cycle();
    if (!last_acc) begin
      exm_valid = 1'b0; exm_we = 1'b0; wb_we = 1'b0; in_rs1_val = 32'h11;
      cycle();
    end
    chk("fwd_accept", 32'(last_acc), 32'd1);
    chk("fwd_srca", srca, 32'h11);

    // x0 never forwards
    offer(32'h108, 5'd0, 5'd0, 5'd8, 32'h33, 32'h44, 32'd0, 1'b0, 1'b0, 6'd1, 1'b1);
    exm_valid = 1'b1; exm_we = 1'b1; exm_rd = 5'd0; exm_data = 32'h11;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h22;
    cycle();
    chk("x0_srca", srca, 32'h33);
    chk("x0_srcb", srcb, 32'h44);

    // load-use: one bubble, then WB data captured
    offer(32'h10C, 5'd1, 5'd4, 5'd9, 32'h1, 32'h55, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1);
    exm_valid = 1'b1; exm_we = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd4; wb_we = 1'b0;
    #1;
    chk("lu_ready", 32'(in_ready), 32'd0);
    cycle();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    exm_valid = 1'b0; exm_we = 1'b0; exm_is_load = 1'b0; exm_rd = 5'd0;
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h99;
    cycle();
    if (!last_acc) begin
      wb_we = 1'b0; in_rs2_val = 32'h99;
      cycle();
    end
    chk("lu_accept", 32'(last_acc), 32'd1);
    chk("lu_srcb", srcb, 32'h99);

    // stall refresh
    idle_inputs();
    cycle();
    offer(32'h110, 5'd6, 5'd0, 5'd10, 32'h10, 32'h0, 32'd0, 1'b0, 1'b0, 6'd2, 1'b1);
    cycle();
    out_ready = 1'b0;
    offer(32'h114, 5'd1, 5'd2, 5'd11, 32'h1, 32'h2, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1);
    cycle();
    chk("bp_no_accept", 32'(last_acc), 32'd0);
    in_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'hAB;
    cycle();
    exp_stall = FWD ? 32'hAB : 32'h10;
    chk("stall_srca", srca, exp_stall);
    wb_we = 1'b0;
    cycle();
    chk("stall_keep", srca, exp_stall);
    out_ready = 1'b1;
    cycle();

    // flush beats capture
    offer(32'h118, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'd0, 1'b0, 1'b0, 6'd4, 1'b1);
    cycle();
    out_ready = 1'b0;
    offer(32'h11C, 5'd1, 5'd2, 5'd13, 32'h1, 32'h2, 32'd0, 1'b0, 1'b0, 6'd5, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    cycle();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;

    // reset while stalled drops the entry
    out_ready = 1'b1;
    offer(32'h120, 5'd1, 5'd2, 5'd14, 32'h1, 32'h2, 32'd0, 1'b0, 1'b0, 6'd6, 1'b1);
    cycle();
    out_ready = 1'b0; in_valid = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_stall_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_we", 32'(out_reg_we), 32'd0);
    chk("rst_stall_srca", srca, 32'd0);
    m_valid = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // random traffic over a small register space to provoke hits
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) != 0)
        offer($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      exm_valid = 1'($urandom_range(0, 1)); exm_we = 1'($urandom_range(0, 1));
      exm_is_load = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3));
      exm_data = $urandom;
      wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the execute ALU. Captures one decoded instruction per accepted handshake, resolves register operands via EX/MEM and WB forwarding, interlocks on load-use hazards, and presents registered `srca`, `srcb` and `alu_ctrl` to the ALU. Uses valid/ready handshakes on both sides and supports flush from branch resolution.

## Interface
- `XLEN`, 32, datapath width
- `CTRL_W`, 6, ALU control width. Encoding matches the ALU: 0 = add … 15 = bgeu.
- `RA_W`, 5, register address width

- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: decode offers an instruction
- `in_ready` out 1: stage accepts this cycle
- `in_pc` in XLEN: instruction PC
- `in_rs1_val` in XLEN: register-file read data for rs1
- `in_rs2_val` in XLEN: register-file read data for rs2
- `in_rs1`, `in_rs2`, `in_rd` in RA_W: register addresses
- `in_imm` in XLEN: sign-extended immediate
- `in_use_imm` in 1: select immediate as `srcb`
- `in_use_pc` in 1: select PC as `srca`
- `in_alu_ctrl` in CTRL_W: ALU operation
- `in_reg_we` in 1: instruction writes `rd`
- `exm_valid`, `exm_we`, `exm_is_load` in 1: EX/MEM stage status
- `exm_rd` in RA_W: EX/MEM destination register
- `exm_data` in XLEN: EX/MEM ALU result
- `wb_we` in 1: writeback write enable
- `wb_rd` in RA_W: writeback destination register
- `wb_data` in XLEN: writeback data
- `flush` in 1: squash the held entry and the incoming entry
- `out_valid` out 1: entry valid toward the ALU
- `out_ready` in 1: execute consumes the entry
- `srca`, `srcb` out XLEN: ALU operands
- `alu_ctrl` out CTRL_W: ALU operation
- `out_pc` out XLEN: PC
- `out_rs2` out XLEN: forwarded rs2, used as store data
- `out_rd` out RA_W: destination register
- `out_reg_we` out 1: write enable

## Operation
- **Storage:** a single entry holds `pc`, `op1`, `op2`, `imm`, `rs1`, `rs2`, `rd`, `use_imm`, `use_pc`, `alu_ctrl`, `reg_we`, and `out_valid`.
- **Output mux:** outputs are purely combinational from the stored entry.
  - `srca` = `use_pc` ? `pc` : `op1`
  - `srcb` = `use_imm` ? `imm` : `op2`
  - `out_rs2` = `op2`
- **Hit:** a source hits a producer when its address is nonzero and equals the producer's `rd` with the producer's write enable set. For EX/MEM, `exm_valid` must also be set. Register x0 never hits.
- **Capture forwarding:** applied when an entry is captured. Priority order:
  1. EX/MEM hit with `exm_is_load` = 0 → use `exm_data`.
  2. WB hit → use `wb_data`.
  3. Otherwise → use `in_rsN_val`.
- **Hold refresh:** while an entry is held (`out_valid` and not `out_ready`), each stored operand is rewritten every cycle using the same priority, with `rs1`/`rs2` as the sources. A producer that retires during a stall is therefore not lost.
- **Load-use hazard:** `in_valid`, `exm_valid`, `exm_is_load`, `exm_we`, and `exm_rd` ≠ 0 matching `in_rs1` or `in_rs2`. This deasserts `in_ready`.
- **Ready:** `in_ready` = (!`out_valid` | `out_ready`) & !hazard & !`flush`.
- **State update:** `out_valid` next =
  - 0 if `flush`;
  - else 1 if (`in_valid` & `in_ready`);
  - else 0 if `out_ready`;
  - else hold.
- **Bubble:** a consumed entry with no new capture leaves `out_valid` = 0. The stored fields keep their last values.

## Timing
- **Reset:** all registers clear asynchronously.
  - `out_valid` = 0, `out_reg_we` = 0.
  - `alu_ctrl` = 0 (add).
  - `srca`, `srcb`, `out_pc`, `out_rs2`, and `out_rd` = 0.
- **Reset release:** `in_ready` = 1 when `in_valid` is asserted with no hazard.
- **Latency:** 1 cycle, input handshake to `out_valid`. Back-to-back throughput is 1 per cycle while `out_ready` = 1.
- **Load-use:** the first hazard cycle inserts exactly one bubble. In the next cycle the load result arrives on WB and is captured via WB forwarding.
- **Simultaneous events:**
  - Consume plus capture in the same cycle keeps `out_valid` = 1 with the new entry.
  - Flush in the same cycle as capture: flush wins, and the input is not accepted.
- **Reset during a stall:** drops the entry with no output pulse.

## Configuration
- **`ID_EX_FWD_EN` defined:** forwarding and hold refresh as described above.
- **`ID_EX_FWD_EN` undefined:**
  - No forwarding; the `exm_data` and `wb_data` ports are unused.
  - `in_ready` also deasserts while `in_rs1` or `in_rs2` (nonzero) matches an EX/MEM write (`exm_valid` & `exm_we`) or a WB write.
  - Operands come only from `in_rsN_val` at capture, with no hold refresh.

## Test plan
- **Reset and basic add:** reset, then `in_valid` with add, `in_rs1_val` = 5, `in_rs2_val` = 7, `in_use_imm` = 0. Expect `out_valid` = 1 the next cycle, `srca` = 5, `srcb` = 7, `alu_ctrl` = 0.
- **Immediate and PC select:** `in_use_pc` = 1, `in_pc` = 0x100, `in_use_imm` = 1, `in_imm` = 0xFFFFFFFC. Expect `srca` = 0x100, `srcb` = 0xFFFFFFFC.
- **Forward priority:** `in_rs1` = 3, EX/MEM write to x3 with `exm_data` = 0x11, WB write to x3 with `wb_data` = 0x22. Expect `srca` = 0x11. With `in_rs1` = 0, expect no forwarding.
- **Load-use:** `exm_is_load` = 1, `exm_rd` = 4, `in_rs2` = 4. Expect `in_ready` = 0 for one cycle. The next cycle, WB x4 = 0x99 is captured: `srcb` = 0x99.
- **Stall refresh:** hold `out_ready` = 0 with the entry's `rs1` = 6, then drive WB x6 = 0xAB. Expect `srca` = 0xAB the cycle after.
- **Flush:** `flush` with `in_valid` = 1 and `out_valid` = 1. Expect `in_ready` = 0, then `out_valid` = 0 the next cycle.
